instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port start, input, 1 bit: begin a new program; clears address and sticky flags.
REQ-004 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): field-bundle handshake.
REQ-005 SHALL have port in_op, input, 4 bits: opcode, CMP=0 J=1 VXOR=2 VXORI=3 VLD=4 VSTR=5 VSR=6 VSL=7 VSWAP=8 ADD=9 SUB=10 ADDI=11 SUBI=12 NOP=13 END=14.
REQ-006 SHALL have ports in_cond (2 bits, EQ=0 GT=1 AL=2 NE=3), in_ra/in_rb/in_rd (4 bits each, integer regs), in_va/in_vd (2 bits each, vector regs), all inputs.
REQ-007 SHALL have ports in_imm (10 bits: immediate or jump address) and in_bsrc/in_bdst (3 bits each: swap bit indices), all inputs.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_word (output, 16), out_addr (output, 10): encoded-word stream to instruction memory.
REQ-009 SHALL have ports done (output, 1): END emitted; err (output, 1): sticky encode fault.

Function
REQ-010 SHALL implement FSM IDLE, RUN, DONE, ERR; start in IDLE/DONE/ERR -> RUN with address counter 0; start in RUN ignored.
REQ-011 SHALL drive in_ready=1 only in RUN and when (!out_valid || out_ready).
REQ-012 SHALL, on accept (in_valid && in_ready), register out_word/out_addr with out_valid=1 next cycle (latency 1), then increment address.
REQ-013 SHALL sustain one word per cycle when out_ready=1 and in_valid=1 with the output register full.
REQ-014 SHALL hold out_word/out_addr stable while out_valid && !out_ready.
REQ-015 SHALL encode opcode in [3:0]; unlisted bits zero.
REQ-016 SHALL encode CMP: ra[13:10], rb[9:6], [15:14]=0.
REQ-017 SHALL encode J: cond[15:14], imm[13:4].
REQ-018 SHALL encode VXOR/VSR/VSL: cond[15:14], va[12:11], vd[10:9], ra[8:5].
REQ-019 SHALL encode VXORI: cond[15:14], va[12:11], vd[10:9], imm[8:4].
REQ-020 SHALL encode VLD: cond, ra[13:10], vd[9:8], imm[7:5]; VSTR: same with va in [9:8].
REQ-021 SHALL encode VSWAP: cond, va[13:12], vd[11:10], bsrc[9:7], bdst[6:4].
REQ-022 SHALL encode ADD/SUB: ra[15:12], rd[11:8], rb[7:4]; ADDI/SUBI: imm[7:4] in place of rb.
REQ-023 SHALL encode NOP/END as opcode only.
REQ-024 SHALL treat in_op=15, or in_imm exceeding field width (VXORI>31, VLD/VSTR>7, ADDI/SUBI>15), as fault: word not emitted, ERR, err=1.
REQ-025 SHALL, after END accepted, drop in_ready and enter DONE when END word handshakes out; done=1 in DONE.
REQ-026 SHALL, if a non-END word is accepted at address 1023, emit it then enter ERR (program overflow).
REQ-027 SHALL, on fault with a word pending, still deliver the pending word.

Reset
REQ-028 SHALL, with rst_n=0, force IDLE, address 0, out_valid=0, out_word=0, out_addr=0, in_ready=0, done=0, err=0.
REQ-029 SHALL, on reset mid-operation, discard any pending word without handshake.

Structure
REQ-030 SHALL take opcode and cond enumerations plus field-width constants from a shared ISA package also used by the decoder.
REQ-031 SHALL isolate field packing in one combinational sub-module instr_pack (fields in, word and fault out); FSM, counter, output register in instr_encoder.

Verification
REQ-032 SHALL check ADD ra=7 rd=15 rb=14 -> out_word 16'h7FE9, out_addr 0.
REQ-033 SHALL check CMP ra=2 rb=3 -> 16'h08C0; VSWAP NE va=2 vd=3 bsrc=5 bdst=1 -> 16'hEE98.
REQ-034 SHALL check J AL imm=5 with out_ready low 3 cycles -> 16'h8051 held stable, in_ready=0 throughout.
REQ-035 SHALL check VXORI imm=32 -> no word emitted, err=1, in_ready=0 until start.
REQ-036 SHALL check NOP, END -> addresses 0,1, done=1 after END handshake; start -> RUN, address 0.
REQ-037 SHALL check rst_n low while out_valid=1 -> all outputs zero immediately.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared ISA definitions for the instruction encoder and decoder:
// opcode/condition enumerations, field widths and the encoder FSM states.
package instr_encoder_pkg;

   localparam int WORD_W      = 16;
   localparam int ADDR_W      = 10;
   localparam int IMM_W       = 10;
   localparam int VXORI_IMM_W = 5;
   localparam int VMEM_IMM_W  = 3;
   localparam int ALUI_IMM_W  = 4;

   typedef enum logic [3:0] {
      OP_CMP   = 4'd0,
      OP_J     = 4'd1,
      OP_VXOR  = 4'd2,
      OP_VXORI = 4'd3,
      OP_VLD   = 4'd4,
      OP_VSTR  = 4'd5,
      OP_VSR   = 4'd6,
      OP_VSL   = 4'd7,
      OP_VSWAP = 4'd8,
      OP_ADD   = 4'd9,
      OP_SUB   = 4'd10,
      OP_ADDI  = 4'd11,
      OP_SUBI  = 4'd12,
      OP_NOP   = 4'd13,
      OP_END   = 4'd14,
      OP_RSVD  = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      COND_EQ = 2'd0,
      COND_GT = 2'd1,
      COND_AL = 2'd2,
      COND_NE = 2'd3
   } cond_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } enc_state_e;

   // True when imm has no bits set at or above position width.
   function automatic logic imm_fits(input logic [IMM_W-1:0] imm, input int width);
      return (imm >> width) == '0;
   endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: places instruction fields into the 16-bit word
// and flags reserved opcodes or immediates too wide for their slot.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  op_e               op,
   input  cond_e             cond,
   input  logic [3:0]        ra,
   input  logic [3:0]        rb,
   input  logic [3:0]        rd,
   input  logic [1:0]        va,
   input  logic [1:0]        vd,
   input  logic [IMM_W-1:0]  imm,
   input  logic [2:0]        bsrc,
   input  logic [2:0]        bdst,
   output logic [WORD_W-1:0] word,
   output logic              fault
);

   always_comb begin
      word      = '0;
      fault     = 1'b0;
      word[3:0] = op;
      case (op)
         OP_CMP: begin
            word[13:10] = ra;
            word[9:6]   = rb;
         end
         OP_J: begin
            word[15:14] = cond;
            word[13:4]  = imm;
         end
         OP_VXOR, OP_VSR, OP_VSL: begin
            word[15:14] = cond;
            word[12:11] = va;
            word[10:9]  = vd;
            word[8:5]   = ra;
         end
         OP_VXORI: begin
            word[15:14] = cond;
            word[12:11] = va;
            word[10:9]  = vd;
            word[8:4]   = imm[VXORI_IMM_W-1:0];
            fault       = !imm_fits(imm, VXORI_IMM_W);
         end
         OP_VLD, OP_VSTR: begin
            word[15:14] = cond;
            word[13:10] = ra;
            word[9:8]   = (op == OP_VLD) ? vd : va;
            word[7:5]   = imm[VMEM_IMM_W-1:0];
            fault       = !imm_fits(imm, VMEM_IMM_W);
         end
         OP_VSWAP: begin
            word[15:14] = cond;
            word[13:12] = va;
            word[11:10] = vd;
            word[9:7]   = bsrc;
            word[6:4]   = bdst;
         end
         OP_ADD, OP_SUB: begin
            word[15:12] = ra;
            word[11:8]  = rd;
            word[7:4]   = rb;
         end
         OP_ADDI, OP_SUBI: begin
            word[15:12] = ra;
            word[11:8]  = rd;
            word[7:4]   = imm[ALUI_IMM_W-1:0];
            fault       = !imm_fits(imm, ALUI_IMM_W);
         end
         OP_NOP, OP_END: ;
         default: fault = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts field bundles, packs them into words and streams
// them with consecutive addresses into instruction memory until END or a fault.
module instr_encoder
   import instr_encoder_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         in_op,
   input  logic [1:0]         in_cond,
   input  logic [3:0]         in_ra,
   input  logic [3:0]         in_rb,
   input  logic [3:0]         in_rd,
   input  logic [1:0]         in_va,
   input  logic [1:0]         in_vd,
   input  logic [IMM_W-1:0]   in_imm,
   input  logic [2:0]         in_bsrc,
   input  logic [2:0]         in_bdst,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WORD_W-1:0]  out_word,
   output logic [ADDR_W-1:0]  out_addr,
   output logic               done,
   output logic               err,
   output enc_state_e         dbg_state
);

   // Handshakes: a transfer occurs on a rising edge where valid && ready; valid
   // never depends on ready, and the payload stays stable while valid && !ready.

   op_e               in_op_e;
   logic [WORD_W-1:0] pack_word;
   logic              pack_fault;
   logic              accept;
   logic              out_fire;

   enc_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              out_valid_q, out_valid_d;
   logic [WORD_W-1:0] out_word_q, out_word_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic              end_pend_q, end_pend_d;
   logic              ovf_pend_q, ovf_pend_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   assign in_op_e = op_e'(in_op);

   instr_pack u_pack (
      .op    (in_op_e),
      .cond  (cond_e'(in_cond)),
      .ra    (in_ra),
      .rb    (in_rb),
      .rd    (in_rd),
      .va    (in_va),
      .vd    (in_vd),
      .imm   (in_imm),
      .bsrc  (in_bsrc),
      .bdst  (in_bdst),
      .word  (pack_word),
      .fault (pack_fault)
   );

   // Intake stops once END or the last address is in flight so nothing follows it.
   assign in_ready = (state_q == ST_RUN) && !end_pend_q && !ovf_pend_q &&
                     (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign out_fire = out_valid_q && out_ready;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      out_valid_d = out_valid_q;
      out_word_d  = out_word_q;
      out_addr_d  = out_addr_q;
      end_pend_d  = end_pend_q;
      ovf_pend_d  = ovf_pend_q;
      done_d      = done_q;
      err_d       = err_q;

      if (out_fire) out_valid_d = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d = ST_RUN;
               addr_d  = '0;
               done_d  = 1'b0;
               err_d   = 1'b0;
            end
         end
         ST_RUN: begin
            if (accept) begin
               if (pack_fault) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else begin
                  out_valid_d = 1'b1;
                  out_word_d  = pack_word;
                  out_addr_d  = addr_q;
                  addr_d      = addr_q + 1'b1;
                  if (in_op_e == OP_END)  end_pend_d = 1'b1;
                  else if (&addr_q)       ovf_pend_d = 1'b1;
               end
            end else if (out_fire && end_pend_q) begin
               state_d    = ST_DONE;
               done_d     = 1'b1;
               end_pend_d = 1'b0;
            end else if (out_fire && ovf_pend_q) begin
               state_d    = ST_ERR;
               err_d      = 1'b1;
               ovf_pend_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         out_valid_q <= 1'b0;
         out_word_q  <= '0;
         out_addr_q  <= '0;
         end_pend_q  <= 1'b0;
         ovf_pend_q  <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         out_valid_q <= out_valid_d;
         out_word_q  <= out_word_d;
         out_addr_q  <= out_addr_d;
         end_pend_q  <= end_pend_d;
         ovf_pend_q  <= ovf_pend_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_word  = out_word_q;
   assign out_addr  = out_addr_q;
   assign done      = done_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule
